// File: rtl/if_id_stage_reg.sv
// rtl/if_id_stage_reg.sv - IF/ID pipeline register with stall, flush and field decode
//
// Purpose:
//   Holds the fetched instruction and its PC+4 between the IF and ID stages.
//   The ID-stage fields are fixed bit slices of the latched instruction.
//   They have no extra latency beyond the register itself.
//
// Optional feature macro: IF_ID_VALID_EN
//   When defined, adds a "valid" output. It marks whether the latched slot
//   holds a real fetched instruction rather than a reset or flush bubble.
//
// Ports:
//   clock        in   1   pipeline clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   IF_IDwrite   in   1   1 = load PCin/instruction, 0 = stall (hold)
//   IF_flush     in   1   1 = latch NOP instead of instruction
//   PCin         in  32   PC+4 of the fetched instruction
//   instruction  in  32   fetched instruction word
//   PCout        out 32   latched PC+4
//   raJump       out 26   latched instruction[25:0]
//   PC4          out  4   latched PC+4 [31:28]
//   ControlIn    out  6   latched instruction[31:26]
//   Rs           out  5   latched instruction[25:21]
//   Rt           out  5   latched instruction[20:16]
//   Rd           out  5   latched instruction[15:11]
//   Immi         out 16   latched instruction[15:0]
//   valid        out  1   latched slot holds a real instruction (IF_ID_VALID_EN only)

module if_id_stage_reg (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        IF_IDwrite,
    input  logic        IF_flush,
    input  logic [31:0] PCin,
    input  logic [31:0] instruction,
    output logic [31:0] PCout,
    output logic [25:0] raJump,
    output logic [3:0]  PC4,
    output logic [5:0]  ControlIn,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
`ifdef IF_ID_VALID_EN
    output logic [15:0] Immi,
    output logic        valid
`else
    output logic [15:0] Immi
`endif
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // The PC follows IF_IDwrite even during a flush. The flushed slot then
    // still carries the PC of the squashed fetch. The instruction becomes
    // the all-zero NOP (sll $0,$0,0).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            if (IF_IDwrite) begin
                pc_q <= PCin;
            end
            if (IF_flush) begin
                instr_q <= 32'd0;
            end else if (IF_IDwrite) begin
                instr_q <= instruction;
            end
        end
    end

`ifdef IF_ID_VALID_EN
    logic valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else if (IF_flush) begin
            valid_q <= 1'b0;
        end else if (IF_IDwrite) begin
            valid_q <= 1'b1;
        end
    end

    assign valid = valid_q;
`endif

    // Decode is type-agnostic. Rd and Immi overlap on [15:11], and ID picks
    // whichever one the opcode needs.
    assign PCout     = pc_q;
    assign PC4       = pc_q[31:28];
    assign ControlIn = instr_q[31:26];
    assign Rs        = instr_q[25:21];
    assign Rt        = instr_q[20:16];
    assign Rd        = instr_q[15:11];
    assign Immi      = instr_q[15:0];
    assign raJump    = instr_q[25:0];

endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb/tb_if_id_stage_reg.sv - randomized self-checking bench for if_id_stage_reg

module tb_if_id_stage_reg;

    logic        clock;
    logic        reset_n;
    logic        IF_IDwrite;
    logic        IF_flush;
    logic [31:0] PCin;
    logic [31:0] instruction;
    logic [31:0] PCout;
    logic [25:0] raJump;
    logic [3:0]  PC4;
    logic [5:0]  ControlIn;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] Immi;
`ifdef IF_ID_VALID_EN
    logic        valid;
`endif

    int checks;
    int errors;

    // Reference state: what ID should currently see.
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic        m_valid;

    if_id_stage_reg dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .IF_IDwrite  (IF_IDwrite),
        .IF_flush    (IF_flush),
        .PCin        (PCin),
        .instruction (instruction),
        .PCout       (PCout),
        .raJump      (raJump),
        .PC4         (PC4),
        .ControlIn   (ControlIn),
        .Rs          (Rs),
        .Rt          (Rt),
        .Rd          (Rd),
`ifdef IF_ID_VALID_EN
        .Immi        (Immi),
        .valid       (valid)
`else
        .Immi        (Immi)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fields are derived arithmetically from the modelled instruction word.
    task automatic check_all(input string tag);
        check({tag, ".PCout"},     PCout,            m_pc);
        check({tag, ".PC4"},       {28'd0, PC4},     m_pc / 32'h1000_0000);
        check({tag, ".ControlIn"}, {26'd0, ControlIn}, m_ins / 32'h0400_0000);
        check({tag, ".Rs"},        {27'd0, Rs},      (m_ins / 32'h0020_0000) % 32);
        check({tag, ".Rt"},        {27'd0, Rt},      (m_ins / 32'h0001_0000) % 32);
        check({tag, ".Rd"},        {27'd0, Rd},      (m_ins / 32'h0000_0800) % 32);
        check({tag, ".Immi"},      {16'd0, Immi},    m_ins % 32'h0001_0000);
        check({tag, ".raJump"},    {6'd0, raJump},   m_ins % 32'h0400_0000);
`ifdef IF_ID_VALID_EN
        check({tag, ".valid"},     {31'd0, valid},   {31'd0, m_valid});
`endif
    endtask

    // Present inputs, clock once, apply the stage rules to the model, compare.
    task automatic step(input string tag, input logic wr, input logic fl,
                        input logic [31:0] pc, input logic [31:0] ins);
        IF_IDwrite  = wr;
        IF_flush    = fl;
        PCin        = pc;
        instruction = ins;
        @(posedge clock);
        #1;
        if (wr) m_pc = pc;
        if (fl) begin
            m_ins   = 32'd0;
            m_valid = 1'b0;
        end else if (wr) begin
            m_ins   = ins;
            m_valid = 1'b1;
        end
        check_all(tag);
    endtask

    // Called just after a rising edge: reset pulse lands mid-cycle.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        m_pc    = 32'd0;
        m_ins   = 32'd0;
        m_valid = 1'b0;
        check_all({tag, ".asserted"});
        reset_n = 1'b1;
        #1;
        check_all({tag, ".released"});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b1;
        IF_IDwrite  = 1'b0;
        IF_flush    = 1'b0;
        PCin        = 32'd0;
        instruction = 32'd0;
        m_pc        = 32'd0;
        m_ins       = 32'd0;
        m_valid     = 1'b0;

        #2;
        reset_n = 1'b0;
        #1;
        check_all("reset");
        #4;
        reset_n = 1'b1;
        #1;
        check_all("reset_release");
        @(posedge clock);
        #1;

        step("lw",        1'b1, 1'b0, 32'h0000_0004, 32'h8E51_0000);
        check("lw.ControlIn_const", {26'd0, ControlIn}, 32'h23);
        check("lw.raJump_const",    {6'd0, raJump},     32'h251_0000);
        step("add",       1'b1, 1'b0, 32'h0000_0008, 32'h0232_8020);
        check("add.Rd_const",       {27'd0, Rd},        32'd16);
        step("stall",     1'b0, 1'b0, 32'h0000_000C, 32'h2009_0014);
        check("stall.PCout_const",  PCout,              32'h8);
        step("addi",      1'b1, 1'b0, 32'h0000_000C, 32'h2009_0014);
        check("addi.Immi_const",    {16'd0, Immi},      32'h14);
        step("flush_wr",  1'b1, 1'b1, 32'h0000_0010, 32'h2709_0014);
        check("flush_wr.PCout_const", PCout,            32'h10);
        step("addi2",     1'b1, 1'b0, 32'h0000_0014, 32'h2009_0014);
        step("flush_st",  1'b0, 1'b1, 32'h0000_0018, 32'h2709_0014);
        check("flush_st.PCout_const", PCout,            32'h14);
        step("jump",      1'b1, 1'b0, 32'hF000_0008, 32'h0800_0003);
        check("jump.PC4_const",     {28'd0, PC4},       32'hF);
        step("flush_j",   1'b1, 1'b1, 32'hF000_000C, 32'h0800_0003);

        step("preload",   1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF);
        step("hold",      1'b0, 1'b0, 32'h0, 32'h0);
        async_reset("reset_in_stall");

        for (int i = 0; i < 300; i++) begin
            logic wr;
            logic fl;
            wr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 5) == 0);
            step("rand", wr, fl, $urandom, $urandom);
            if ($urandom_range(0, 39) == 0) async_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
